// File: rtl/rr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter_if : request/grant bundle between requesters and rr_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  modport master (output req, input gnt, gnt_valid, gnt_id, preempt);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, preempt);
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : N-way round-robin arbiter with registered one-hot grant and
//              max-hold preemption (only when another requester waits)
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter_if.slave bus
);

  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam logic [IDW-1:0] C_LAST = IDW'(N - 1);
  localparam logic [HW-1:0]  C_HMAX = HW'(MAX_HOLD);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           preempt_q, preempt_d;

  logic [N-1:0]   w_others;
  logic           w_owner_req;
  logic [IDW-1:0] w_next;
  logic [IDW-1:0] w_start;
  logic [N-1:0]   w_vec;
  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic           w_do_grant;

  // Circular first-set search starting at 'start'; returns {found, index}.
  function automatic logic [IDW:0] pick(input logic [IDW-1:0] start,
                                        input logic [N-1:0]   vec);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDW'((int'(start) + k) % N);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

  assign w_others    = bus.req & ~gnt_q;
  assign w_owner_req = |(bus.req & gnt_q);
  assign w_next      = (id_q == C_LAST) ? '0 : id_q + IDW'(1);
  assign w_start     = (state_q == ST_IDLE) ? ptr_q   : w_next;
  assign w_vec       = (state_q == ST_IDLE) ? bus.req : w_others;
  assign {w_found, w_sel} = pick(w_start, w_vec);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    preempt_d  = 1'b0;
    w_do_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_do_grant = w_found;
      end
      ST_GRANT: begin
        if (!w_owner_req) begin
          if (w_found) begin
            w_do_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q == C_HMAX && w_found) begin
          w_do_grant = 1'b1;
          preempt_d  = 1'b1;
        end else if (hold_q != C_HMAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_do_grant) begin
      state_d       = ST_GRANT;
      gnt_d         = '0;
      gnt_d[w_sel]  = 1'b1;
      id_d          = w_sel;
      ptr_d         = (w_sel == C_LAST) ? '0 : w_sel + IDW'(1);
      hold_d        = HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.preempt   = preempt_q;

endmodule
`default_nettype wire

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one single-owner resource (e.g. shared memory or bus port) among N requesters.
- Requesters hold `req` high for as long as they need the resource. The arbiter issues a registered one-hot grant.
- Enforces a maximum hold time: a hog is preempted only when another requester is waiting.
- Sits between requesting units and the shared datapath and drives that datapath's select/enable.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation when others wait; legal range 2..256.
- IDW, $clog2(N), width of gnt_id; derived, not overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants or keeps the resource.
- gnt  output  N  one-hot grant vector, registered; all-zero when idle.
- gnt_valid  output  1  high when any gnt bit is set; equals OR of gnt.
- gnt_id  output  IDW  binary index of current owner; holds last owner when gnt_valid=0.
- preempt  output  1  one-cycle pulse in the cycle after a timeout-forced handoff.

Behaviour:
- Reset: synchronous and active-high.
  - rst=1 at a rising edge forces gnt=0, gnt_valid=0, gnt_id=0 and preempt=0.
  - It also sets the priority pointer ptr=0, hold_cnt=0 and state=IDLE.
  - rst overrides all other activity, including an in-progress grant.
- State IDLE (no owner):
  - If req≠0, select the first set bit scanning circularly from ptr: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Register gnt=onehot(sel) and gnt_id=sel; go to GRANT; hold_cnt=1.
  - Latency from request to grant is exactly 1 cycle.
- State GRANT (owner o):
  - Keep: req[o]=1 and (hold_cnt<MAX_HOLD or no other req bit set).
    - gnt unchanged.
    - hold_cnt increments, saturating at MAX_HOLD.
    - If the owner is alone at MAX_HOLD, hold_cnt is held at MAX_HOLD and there is no preempt.
  - Release: req[o]=0.
    - Same-cycle rearbitration, scanning from (o+1) mod N while excluding o.
    - If another bit is set, gnt moves directly to the winner next cycle with no idle gap, and hold_cnt=1.
    - Otherwise gnt=0 next cycle and the state goes to IDLE.
  - Preempt: req[o]=1, hold_cnt==MAX_HOLD and some req[j]=1 with j≠o.
    - Grant moves to the next requester scanning from (o+1) mod N; hold_cnt=1.
    - preempt=1 for exactly that first cycle of the new grant.
- Pointer update: whenever a grant is issued to index s, ptr <= (s+1) mod N. Wrap from N-1 to 0 is required.
- Fairness: any continuously requesting index is granted within (N-1)*MAX_HOLD+1 cycles of asserting req.
- Invariants (checked every cycle):
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt[gnt_id]=1.
  - gnt never points at a requester whose req was low in the previous cycle.
- Requests may assert or drop on any cycle; no minimum pulse width.
- A 1-cycle req pulse in IDLE yields a 1-cycle grant followed by release.

Test Plan:
- Reset: assert rst 2 cycles with req=4'b1111.
  -> gnt=0, gnt_valid=0, gnt_id=0, preempt=0 during reset.
  -> First grant, 1 cycle after rst drops, is gnt=4'b0001.
- Single requester: req=4'b0100 from cycle 0, dropped at cycle 5.
  -> gnt=4'b0100, gnt_id=2 on cycles 1..5.
  -> gnt=0 on cycle 6.
  -> Next req=4'b1111 grants index 3, because ptr=3.
- Round-robin handoff: req=4'b1111 after reset; each owner drops its bit 3 cycles after being granted.
  -> Grant order is 0,1,2,3, each held 3 cycles, with no idle cycle between owners.
- Timeout preempt: MAX_HOLD=4, req=4'b0011 held continuously.
  -> Grant alternates 0,1,0,1 every 4 cycles.
  -> preempt pulses once at each handoff.
- Lone hog: MAX_HOLD=4, only req=4'b1000 held 20 cycles.
  -> gnt=4'b1000 for all 20 cycles with preempt never asserted.
  -> When req[0] is then raised, handoff to 0 occurs on the next cycle with preempt=1.
- Reset mid-grant: owner 2 granted, rst pulsed 1 cycle with req=4'b0100 still high.
  -> gnt=0 on the cycle after rst.
  -> Regrant to index 2 one cycle after rst deasserts; ptr was reset to 0, and 2 is the first set bit.
